// File: rtl/tx_ctrl_pkg.sv
// Shared definitions for the serial transmit control path: FSM state codes,
// baud timing constants and the frame-length helper.
package tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2,
    ST_STOP = 2'd3
  } tx_state_e;

  localparam int BIT_CYC = 100;
  localparam int BPS_MID = 50;

  // Cycles occupied on the line by one frame: start + payload + stop bits.
  function automatic int frame_cycles(input int data_w, input int stop_bits);
    return BIT_CYC * (1 + data_w + stop_bits);
  endfunction

endpackage

// File: rtl/tx_arbiter_module_if.sv
// Requester-side bus of the transmit arbiter: level requests with their data,
// and the arbiter's acknowledge / grant / status returns.
interface tx_arbiter_module_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  import tx_ctrl_pkg::*;

  logic [N_REQ-1:0]        Req;
  logic [N_REQ*DATA_W-1:0] Req_Data;
  logic [N_REQ-1:0]        Ack;
  logic [N_REQ-1:0]        Grant;
  logic                    Busy;
  logic                    Done;

  modport master (
    output Req, Req_Data,
    input  Ack, Grant, Busy, Done
  );

  modport slave (
    input  Req, Req_Data,
    output Ack, Grant, Busy, Done
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot winner is the first set request
// at or after the pointer, wrapping modulo N_REQ.
module rr_arbiter
  import tx_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] Req,
  input  logic [PTR_W-1:0] Ptr,
  output logic [N_REQ-1:0] Winner,
  output logic             any_req
);

  logic [PTR_W:0] pos;
  logic           found;

  always_comb begin
    Winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, Ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(N_REQ)) pos = pos - (PTR_W+1)'(N_REQ);
      if (!found && Req[pos[PTR_W-1:0]]) begin
        Winner[pos[PTR_W-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
  end

  assign any_req = |Req;

endmodule

// File: rtl/tx_arbiter_module.sv
// Round-robin scheduler sharing one serial TX line among N_REQ byte requesters;
// frame bits are stepped by the baud generator's mid-bit BPS_CLK tick.
module tx_arbiter_module
  import tx_ctrl_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                CLK,
  input  logic                RST,
  tx_arbiter_module_if.slave  req_bus,
  output logic                Count_Sig,
  input  logic                BPS_CLK,
  output logic                TX_Pin_Out
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int IDX_W = $clog2(DATA_W + 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_DATA = ST_DATA;
  localparam logic [1:0] S_STOP = ST_STOP;

  logic [1:0]        state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [1:0]        stop_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic [N_REQ-1:0]  grant_reg;
  logic [N_REQ-1:0]  ack_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              count_reg;
  logic              tx_reg;

  logic [N_REQ-1:0]  winner;
  logic              any_req;
  logic [PTR_W-1:0]  ptr_next;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] lane_masked [N_REQ];

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .Req     (req_bus.Req),
    .Ptr     (ptr_reg),
    .Winner  (winner),
    .any_req (any_req)
  );

  // Only the winner's lane reaches the shift register; other lanes are masked off.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane_masked[gi] = winner[gi] ? req_bus.Req_Data[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    ptr_next = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data = sel_data | lane_masked[i];
      if (winner[i]) ptr_next = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      stop_reg  <= '0;
      ptr_reg   <= '0;
      grant_reg <= '0;
      ack_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      count_reg <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      ack_reg  <= '0;
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (any_req) begin
            shift_reg <= sel_data;
            grant_reg <= winner;
            ack_reg   <= winner;
            busy_reg  <= 1'b1;
            count_reg <= 1'b1;
            ptr_reg   <= ptr_next;
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (BPS_CLK) begin
            tx_reg    <= 1'b0;
            idx_reg   <= '0;
            state_reg <= S_DATA;
          end
        end
        S_DATA: begin
          if (BPS_CLK) begin
            if (idx_reg == IDX_W'(DATA_W)) begin
              tx_reg    <= 1'b1;
              stop_reg  <= '0;
              state_reg <= S_STOP;
            end else begin
              // Shifting right presents shift[idx] at bit 0, LSB first.
              tx_reg    <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              idx_reg   <= idx_reg + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (BPS_CLK) begin
            if (stop_reg == 2'(STOP_BITS - 1)) begin
              count_reg <= 1'b0;
              grant_reg <= '0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              tx_reg    <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              stop_reg <= stop_reg + 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign req_bus.Ack   = ack_reg;
  assign req_bus.Grant = grant_reg;
  assign req_bus.Busy  = busy_reg;
  assign req_bus.Done  = done_reg;
  assign Count_Sig     = count_reg;
  assign TX_Pin_Out    = tx_reg;

endmodule
